audio_mix_sequencer: RTL and testbench

- Time-multiplexed audio mixer controller. It shares one 8x4 multiply-accumulate datapath across NCH unsigned 8-bit sources: the 8253 beeper expanded to 8 bits, AY A/B/C, RS A/B/C and covox.
- Produces one 16-bit mixed sample per SAMPLE_DIV clocks.
- Sits between the sound sources and the delta-sigma PWM stage, replacing the fixed adder tree with a scheduled MAC and per-channel gain.

---
 rtl/audio_mix_pkg.sv | 31 +++
 rtl/audio_mix_sequencer_if.sv | 30 +++
 rtl/mixseq_mac.sv | 39 +++
 rtl/audio_mix_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_audio_mix_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/audio_mix_pkg.sv
// Shared types and constants for the audio mix sequencer.
// Holds the FSM state encoding, datapath widths and the dither LFSR constants.
package audio_mix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_SAT  = 2'd2
  } mix_state_e;

  localparam int SAMPLE_W = 8;
  localparam int GAIN_W   = 4;
  localparam int ACC_W    = 16;
  localparam int OUT_W    = 16;
  localparam int PROD_W   = SAMPLE_W + GAIN_W;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // One step of the right-shifting Galois LFSR used for output dither.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic [15:0] shifted;
    shifted = {1'b0, cur[15:1]};
    if (cur[0]) begin
      return shifted ^ LFSR_TAPS;
    end else begin
      return shifted;
    end
  endfunction

endpackage

// File: rtl/audio_mix_sequencer_if.sv
// Bus bundle between the sound sources / config port and the mix sequencer.
// The master side drives samples and configuration; the slave (sequencer)
// returns the mixed sample and status.
interface audio_mix_sequencer_if #(
  parameter int NCH = 8
);
  import audio_mix_pkg::*;

  logic [NCH*SAMPLE_W-1:0] ch_in;
  logic [NCH-1:0]          ch_en;
  logic                    cfg_we;
  logic [2:0]              cfg_addr;
  logic [GAIN_W-1:0]       cfg_gain;
  logic                    clip_clr;
  logic [OUT_W-1:0]        mix_out;
  logic                    mix_valid;
  logic                    busy;
  logic                    clip;

  modport master (
    output ch_in, ch_en, cfg_we, cfg_addr, cfg_gain, clip_clr,
    input  mix_out, mix_valid, busy, clip
  );

  modport slave (
    input  ch_in, ch_en, cfg_we, cfg_addr, cfg_gain, clip_clr,
    output mix_out, mix_valid, busy, clip
  );

endinterface

// File: rtl/mixseq_mac.sv
// Shared multiply-accumulate unit: one 8x4 unsigned product per enabled
// cycle is added into a 16-bit accumulator. clr zeroes the accumulator and
// takes priority over en.
module mixseq_mac
  import audio_mix_pkg::*;
(
  input  logic                clk24,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [GAIN_W-1:0]   gain,
  output logic [ACC_W-1:0]    acc
);

  logic [PROD_W-1:0] prod_s;
  logic [ACC_W-1:0]  acc_r;

  // Unsigned 8x4 product, widened before multiplying so no bits are lost.
  always_comb begin
    prod_s = PROD_W'(sample) * PROD_W'(gain);
  end

  // Accumulator register with clear/enable.
  always_ff @(posedge clk24) begin
    if (reset) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (clr) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (en) begin
      acc_r <= acc_r + ACC_W'(prod_s);
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/audio_mix_sequencer.sv
// Time-multiplexed audio mixer: every SAMPLE_DIV clocks it snapshots the
// enabled channel samples and their gains, runs them through one shared MAC
// over NCH cycles, then shifts and saturates to a 16-bit output sample.
// Optional build macro: MIXSEQ_DITHER_EN adds 2 LSBs of LFSR dither to the
// accumulator before shift/saturation.
module audio_mix_sequencer
  import audio_mix_pkg::*;
#(
  parameter int NCH        = 8,
  parameter int SAMPLE_DIV = 512,
  parameter int OUT_SHIFT  = 2,
  parameter int GAIN_RESET = 4
) (
  input  logic                 clk24,
  input  logic                 reset,
  audio_mix_sequencer_if.slave bus
);

  localparam int IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  // One spare bit so accumulator plus dither cannot wrap before the shift.
  localparam int FULL_W = ACC_W + OUT_SHIFT + 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NCH - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [GAIN_W-1:0] GAIN_INIT = GAIN_W'(GAIN_RESET);

  // The schedule needs room for snapshot, NCH MAC cycles and saturation.
  if (SAMPLE_DIV < NCH + 3) begin : g_div_check
    $error("SAMPLE_DIV must be at least NCH+3");
  end

  logic [DIV_W-1:0]    div_r;
  logic                tick_s;
  mix_state_e          state_r;
  mix_state_e          state_s;
  logic [IDX_W-1:0]    idx_r;
  logic [GAIN_W-1:0]   gain_r  [NCH];
  logic [SAMPLE_W-1:0] snap_r  [NCH];
  logic [GAIN_W-1:0]   gsnap_r [NCH];
  logic                mac_clr_s;
  logic                mac_en_s;
  logic [ACC_W-1:0]    acc_s;
  logic [FULL_W-1:0]   pre_s;
  logic [FULL_W-1:0]   full_s;
  logic                sat_s;
  logic [OUT_W-1:0]    mix_out_r;
  logic                mix_valid_r;
  logic                busy_r;
  logic                clip_r;

  assign tick_s = (div_r == DIV_LAST);

  // Free-running sample-rate divider.
  always_ff @(posedge clk24) begin
    if (reset) begin
      div_r <= {DIV_W{1'b0}};
    end else if (tick_s) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk24) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and MAC control.
  always_comb begin
    state_s   = state_r;
    mac_clr_s = 1'b0;
    mac_en_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s) begin
          state_s   = ST_MAC;
          mac_clr_s = 1'b1;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_MAC: begin
        mac_en_s = 1'b1;
        if (idx_r == IDX_LAST) begin
          state_s = ST_SAT;
        end else begin
          state_s = ST_MAC;
        end
      end
      ST_SAT: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Gain register file; addresses at or above NCH match no entry.
  always_ff @(posedge clk24) begin
    for (int k = 0; k < NCH; k++) begin
      if (reset) begin
        gain_r[k] <= GAIN_INIT;
      end else if (bus.cfg_we && (int'(bus.cfg_addr) == k)) begin
        gain_r[k] <= bus.cfg_gain;
      end else begin
        gain_r[k] <= gain_r[k];
      end
    end
  end

  // Shadow copies of samples and gains, frozen for the whole sample.
  always_ff @(posedge clk24) begin
    for (int k = 0; k < NCH; k++) begin
      if (reset) begin
        snap_r[k]  <= {SAMPLE_W{1'b0}};
        gsnap_r[k] <= {GAIN_W{1'b0}};
      end else if ((state_r == ST_IDLE) && tick_s) begin
        snap_r[k]  <= bus.ch_en[k] ? bus.ch_in[k*SAMPLE_W +: SAMPLE_W] : {SAMPLE_W{1'b0}};
        gsnap_r[k] <= gain_r[k];
      end else begin
        snap_r[k]  <= snap_r[k];
        gsnap_r[k] <= gsnap_r[k];
      end
    end
  end

  // Channel index walked by the MAC phase.
  always_ff @(posedge clk24) begin
    if (reset) begin
      idx_r <= {IDX_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: idx_r <= {IDX_W{1'b0}};
        ST_MAC:  idx_r <= idx_r + IDX_W'(1);
        ST_SAT:  idx_r <= {IDX_W{1'b0}};
        default: idx_r <= {IDX_W{1'b0}};
      endcase
    end
  end

  mixseq_mac u_mac (
    .clk24  (clk24),
    .reset  (reset),
    .clr    (mac_clr_s),
    .en     (mac_en_s),
    .sample (snap_r[idx_r]),
    .gain   (gsnap_r[idx_r]),
    .acc    (acc_s)
  );

`ifdef MIXSEQ_DITHER_EN
  logic [15:0] lfsr_r;

  // Dither LFSR, advanced once per finished sample.
  always_ff @(posedge clk24) begin
    if (reset) begin
      lfsr_r <= LFSR_SEED;
    end else if (state_r == ST_SAT) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  // Accumulator plus dither, shifted, with overflow detection.
  always_comb begin
    pre_s  = FULL_W'(acc_s) + FULL_W'(lfsr_r[1:0]);
    full_s = pre_s << OUT_SHIFT;
    sat_s  = |full_s[FULL_W-1:OUT_W];
  end
`else
  // Accumulator shifted to output scale, with overflow detection.
  always_comb begin
    pre_s  = FULL_W'(acc_s);
    full_s = pre_s << OUT_SHIFT;
    sat_s  = |full_s[FULL_W-1:OUT_W];
  end
`endif

  // Registered outputs: sample, valid pulse, busy and sticky clip.
  always_ff @(posedge clk24) begin
    if (reset) begin
      mix_out_r   <= {OUT_W{1'b0}};
      mix_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      clip_r      <= 1'b0;
    end else begin
      busy_r      <= (state_s != ST_IDLE);
      mix_valid_r <= (state_r == ST_SAT);
      if (state_r == ST_SAT) begin
        mix_out_r <= sat_s ? {OUT_W{1'b1}} : full_s[OUT_W-1:0];
      end else begin
        mix_out_r <= mix_out_r;
      end
      // A saturation on the same edge as a clear leaves the flag set.
      if ((state_r == ST_SAT) && sat_s) begin
        clip_r <= 1'b1;
      end else if (bus.clip_clr) begin
        clip_r <= 1'b0;
      end else begin
        clip_r <= clip_r;
      end
    end
  end

  assign bus.mix_out   = mix_out_r;
  assign bus.mix_valid = mix_valid_r;
  assign bus.busy      = busy_r;
  assign bus.clip      = clip_r;

endmodule

// File: tb/tb_audio_mix_sequencer.sv
// Directed bench for audio_mix_sequencer (default build, no dither).
// A vector table covers the steady-state mixing cases; hand-written
// sequences cover latency, gain writes on the tick edge, mid-sample input
// changes, mid-sample reset and the clip set/clear priority.
module tb_audio_mix_sequencer;

  localparam int NCH        = 8;
  localparam int SAMPLE_DIV = 512;
  localparam int TICK_GAP   = SAMPLE_DIV - NCH - 1;

  typedef struct {
    string       name;
    logic [63:0] ch;
    logic [7:0]  en;
    logic [31:0] gains;
    logic        clr;
    logic [15:0] exp_out;
    logic        exp_clip;
  } vec_t;

  logic clk24 = 1'b0;
  logic reset = 1'b1;
  int   cnt   = 0;
  int   fails = 0;
  vec_t tab[7];

  audio_mix_sequencer_if #(.NCH(NCH)) bus ();

  audio_mix_sequencer #(
    .NCH(NCH), .SAMPLE_DIV(SAMPLE_DIV), .OUT_SHIFT(2), .GAIN_RESET(4)
  ) dut (
    .clk24 (clk24),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk24 = ~clk24;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk24);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cnt++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk24);
      #1;
      n++;
    end while (!bus.mix_valid && n < 1200);
    if (!bus.mix_valid) begin
      cnt++;
      fails++;
      $display("FAIL valid_timeout: got no mix_valid, expected one within 1200 cycles");
    end
  endtask

  task automatic set_gains(input logic [31:0] g);
    for (int k = 0; k < NCH; k++) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'(k);
      bus.cfg_gain = g[4*k +: 4];
      step(1);
    end
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    int n;
    tab[0] = '{"mask_ch1",   64'h0000_0000_0000_0A0A, 8'h01, 32'h4444_4444, 1'b0, 16'h00A0, 1'b0};
    tab[1] = '{"ramp",       64'h0807_0605_0403_0201, 8'hFF, 32'h8765_4321, 1'b0, 16'h0330, 1'b0};
    tab[2] = '{"odd_mask",   64'hC8C8_C8C8_C8C8_C8C8, 8'hAA, 32'h2222_2222, 1'b0, 16'h1900, 1'b0};
    tab[3] = '{"below_sat",  64'h0000_3FFF_FFFF_FFFF, 8'hFF, 32'h0014_FFFF, 1'b0, 16'hFFFC, 1'b0};
    tab[4] = '{"at_sat",     64'h0000_40FF_FFFF_FFFF, 8'hFF, 32'h0014_FFFF, 1'b0, 16'hFFFF, 1'b1};
    tab[5] = '{"full_scale", 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 32'hFFFF_FFFF, 1'b0, 16'hFFFF, 1'b1};
    tab[6] = '{"clear_zero", 64'h0000_0000_0000_0000, 8'hFF, 32'hFFFF_FFFF, 1'b1, 16'h0000, 1'b0};

    bus.ch_in    = 64'h0;
    bus.ch_en    = 8'h00;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = 3'd0;
    bus.cfg_gain = 4'd0;
    bus.clip_clr = 1'b0;

    // Reset state.
    step(3);
    check("rst_mix_out", bus.mix_out, 32'h0);
    check("rst_valid", bus.mix_valid, 32'h0);
    check("rst_busy", bus.busy, 32'h0);
    check("rst_clip", bus.clip, 32'h0);

    // Reset gains, ch0=100: latency from reset release, pulse width, period.
    bus.ch_in = 64'd100;
    bus.ch_en = 8'hFF;
    reset = 1'b0;
    wait_valid(n);
    check("first_latency", n, SAMPLE_DIV + NCH + 1);
    check("ch0_100_out", bus.mix_out, 32'h0640);
    check("ch0_100_clip", bus.clip, 32'h0);
    step(1);
    check("valid_one_cycle", bus.mix_valid, 32'h0);
    check("idle_busy", bus.busy, 32'h0);
    wait_valid(n);
    check("sample_period", n, SAMPLE_DIV - 1);
    check("ch0_100_out2", bus.mix_out, 32'h0640);

    // Table vectors, each applied right after a valid pulse.
    for (int i = 0; i < 7; i++) begin
      set_gains(tab[i].gains);
      bus.ch_in = tab[i].ch;
      bus.ch_en = tab[i].en;
      if (tab[i].clr) begin
        bus.clip_clr = 1'b1;
        step(1);
        bus.clip_clr = 1'b0;
      end
      wait_valid(n);
      check({tab[i].name, "_out"}, bus.mix_out, 32'(tab[i].exp_out));
      check({tab[i].name, "_clip"}, bus.clip, 32'(tab[i].exp_clip));
    end

    // Gain write on the tick edge is not seen until the following sample.
    set_gains(32'h4444_4444);
    bus.ch_in = 64'd10;
    bus.ch_en = 8'hFF;
    wait_valid(n);
    check("g4_out", bus.mix_out, 32'h00A0);
    step(TICK_GAP - 1);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'd0;
    bus.cfg_gain = 4'hF;
    step(1);
    bus.cfg_we = 1'b0;
    check("tick_busy", bus.busy, 32'h1);
    wait_valid(n);
    check("tick_latency", n, NCH + 1);
    check("tick_write_out", bus.mix_out, 32'h00A0);
    wait_valid(n);
    check("after_write_out", bus.mix_out, 32'h0258);

    // Inputs changing during MAC do not affect the sample in flight.
    step(TICK_GAP + 2);
    bus.ch_in = 64'hFFFF_FFFF_FFFF_FFFF;
    wait_valid(n);
    check("mac_change_lat", n, NCH - 1);
    check("mac_change_out", bus.mix_out, 32'h0258);
    wait_valid(n);
    check("new_snap_out", bus.mix_out, 32'hAB54);

    // Reset three cycles into a sample aborts it and restores gains.
    step(TICK_GAP + 3);
    check("mid_busy", bus.busy, 32'h1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("abort_busy", bus.busy, 32'h0);
    check("abort_out", bus.mix_out, 32'h0);
    check("abort_valid", bus.mix_valid, 32'h0);
    wait_valid(n);
    check("abort_latency", n, SAMPLE_DIV + NCH + 1);
    check("abort_next_out", bus.mix_out, 32'h7F80);

    // Clear held through a saturating sample: set wins, then clear applies.
    set_gains(32'hFFFF_FFFF);
    bus.clip_clr = 1'b1;
    wait_valid(n);
    check("set_wins_clip", bus.clip, 32'h1);
    check("set_wins_out", bus.mix_out, 32'hFFFF);
    step(1);
    bus.clip_clr = 1'b0;
    check("clr_after_clip", bus.clip, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", cnt, fails);
    $finish;
  end

endmodule
